// File: rtl/spw_rx_port_pkg.sv
// Shared definitions for the SpaceWire receive FIFO register port:
// register addresses, STATUS/CONTROL bit positions and the prefetch FSM states.
package spw_rx_port_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_STATUS   = 2'd1;
    localparam logic [1:0] ADDR_CONTROL  = 2'd2;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd3;

    localparam int unsigned DATA_VALID_BIT = 31;

    localparam int unsigned STAT_VALID   = 0;
    localparam int unsigned STAT_EMPTY   = 1;
    localparam int unsigned STAT_UFLOW   = 2;
    localparam int unsigned STAT_CNT_LSB = 16;

    localparam int unsigned CTRL_FLUSH = 0;
    localparam int unsigned CTRL_CLEAR = 1;

    localparam int unsigned IRQ_DATA = 0;
    localparam int unsigned IRQ_EOP  = 1;

    typedef enum logic [1:0] {
        EMPTY,
        WAIT,
        FULL
    } rx_state_t;

endpackage

// File: rtl/spw_rx_fifo_port_if.sv
// Avalon-MM register bus between the interconnect (master) and the
// receive FIFO port (slave).
interface spw_rx_fifo_port_if;

    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/spw_rx_fifo_port.sv
// Avalon-MM window onto the SpaceWire receive FIFO: one-word prefetch, pop on DATA read.
// Optional interrupt and IRQ_MASK register when SPW_RX_PORT_IRQ_EN is defined.
module spw_rx_fifo_port
    import spw_rx_port_pkg::*;
#(
    parameter int unsigned DATA_W = 9,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    spw_rx_fifo_port_if.slave bus,
    input  logic [DATA_W-1:0] fifo_q,
    input  logic              fifo_empty,
    output logic              fifo_rdreq
`ifdef SPW_RX_PORT_IRQ_EN
    ,
    output logic              irq
`endif
);

    rx_state_t         state;
    rx_state_t         state_nxt;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] hold_d;
    logic              hold_load;
    logic              underflow;
    logic [CNT_W-1:0]  count;
    logic [31:0]       rd_mux;

    logic data_rd;
    logic ctrl_wr;
    logic flush;
    logic clear;
    logic hold_valid;
    logic pop;
    logic uflow_set;
    logic unused_wdata;

    always_comb begin
        data_rd    = bus.read && (bus.address == ADDR_DATA);
        ctrl_wr    = bus.write && (bus.address == ADDR_CONTROL);
        flush      = ctrl_wr && bus.writedata[CTRL_FLUSH];
        clear      = ctrl_wr && bus.writedata[CTRL_CLEAR];
        hold_valid = (state == FULL);
        pop        = data_rd && hold_valid;
        uflow_set  = data_rd && !hold_valid;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (!fifo_empty) state_nxt = WAIT;
            WAIT:  state_nxt = flush ? EMPTY : FULL;
            FULL: begin
                // Flush overrides the refill a same-cycle DATA read would start.
                if (flush) begin
                    state_nxt = EMPTY;
                end else if (data_rd) begin
                    state_nxt = fifo_empty ? EMPTY : WAIT;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        fifo_rdreq = 1'b0;
        hold_load  = 1'b0;
        unique case (state)
            EMPTY:   fifo_rdreq = !fifo_empty;
            WAIT:    hold_load  = !flush;
            FULL:    fifo_rdreq = data_rd && !flush && !fifo_empty;
            default: fifo_rdreq = 1'b0;
        endcase
    end

    always_comb begin
        hold_d = hold;
        if (hold_load) begin
            hold_d = fifo_q;
        end else if (flush) begin
            hold_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold      <= '0;
            underflow <= 1'b0;
            count     <= '0;
        end else begin
            hold <= hold_d;
            if (clear) begin
                underflow <= 1'b0;
                count     <= '0;
            end else begin
                if (uflow_set) underflow <= 1'b1;
                if (pop)       count     <= count + CNT_W'(1);
            end
        end
    end

`ifdef SPW_RX_PORT_IRQ_EN
    logic [1:0] irq_mask;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            if (bus.write && (bus.address == ADDR_IRQ_MASK)) begin
                irq_mask <= bus.writedata[1:0];
            end
            // Built from next-cycle state so irq drops together with the popped word.
            irq <= (state_nxt == FULL) &&
                   (irq_mask[IRQ_DATA] || (irq_mask[IRQ_EOP] && hold_d[DATA_W-1]));
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        unique case (bus.address)
            ADDR_DATA: begin
                if (hold_valid) begin
                    rd_mux[DATA_W-1:0]     = hold;
                    rd_mux[DATA_VALID_BIT] = 1'b1;
                end
            end
            ADDR_STATUS: begin
                rd_mux[STAT_VALID]              = hold_valid;
                rd_mux[STAT_EMPTY]              = fifo_empty;
                rd_mux[STAT_UFLOW]              = underflow;
                rd_mux[STAT_CNT_LSB +: CNT_W]   = count;
            end
`ifdef SPW_RX_PORT_IRQ_EN
            ADDR_IRQ_MASK: rd_mux[1:0] = irq_mask;
`endif
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else if (bus.read) begin
            bus.readdata <= rd_mux;
        end
    end

    always_comb unused_wdata = ^bus.writedata[31:2];

endmodule

// File: tb/tb_spw_rx_fifo_port.sv
// Scoreboard bench for spw_rx_fifo_port: directed stimulus queues expectations,
// a monitor compares them against readdata and sampled side signals.
module tb_spw_rx_fifo_port;

    typedef struct {
        string       name;
        logic [31:0] got;
        logic [31:0] exp;
    } chk_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    spw_rx_fifo_port_if bus ();

    logic [8:0] fifo_q     = '0;
    logic       fifo_empty = 1'b1;
    logic       fifo_rdreq;
`ifdef SPW_RX_PORT_IRQ_EN
    logic       irq;
`endif

    logic       push_en   = 1'b0;
    logic [8:0] push_word = '0;
    logic [8:0] fifo_mem[$];

    chk_t exp_q[$];
    chk_t chk_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   rdreq_cnt = 0;

    spw_rx_fifo_port #(
        .DATA_W(9),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .fifo_q    (fifo_q),
        .fifo_empty(fifo_empty),
        .fifo_rdreq(fifo_rdreq)
`ifdef SPW_RX_PORT_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    // Normal-mode FIFO model: word appears on fifo_q the cycle after rdreq.
    always @(posedge clk) begin : fifo_model
        if (fifo_rdreq && fifo_mem.size() > 0) fifo_q <= fifo_mem.pop_front();
        if (push_en) fifo_mem.push_back(push_word);
        fifo_empty <= (fifo_mem.size() == 0);
    end

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    endfunction

    always @(posedge clk) begin : monitor
        logic rd_s;
        logic rq_s;
        logic fe_s;
        chk_t e;
        rd_s = bus.read;
        rq_s = fifo_rdreq;
        fe_s = fifo_empty;
        #1;
        if (rq_s) begin
            rdreq_cnt++;
            check("rdreq_while_empty", 32'(fe_s), 32'h0);
        end
        if (rd_s) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read", bus.readdata, 32'hDEAD_BEEF);
            end else begin
                e = exp_q.pop_front();
                check(e.name, bus.readdata, e.exp);
            end
        end
        while (chk_q.size() > 0) begin
            e = chk_q.pop_front();
            check(e.name, e.got, e.exp);
        end
    end

    task automatic rd(input logic [1:0] a, input string n, input logic [31:0] e);
        @(negedge clk);
        bus.address = a;
        bus.read    = 1'b1;
        exp_q.push_back('{n, 32'h0, e});
        @(negedge clk);
        bus.read = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address   = a;
        bus.writedata = d;
        bus.write     = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic push(input logic [8:0] w);
        @(negedge clk);
        push_en   = 1'b1;
        push_word = w;
        @(negedge clk);
        push_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_now(input string n, input logic [31:0] got, input logic [31:0] e);
        chk_q.push_back('{n, got, e});
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int rq0;
        logic [8:0] w;
        bus.address   = '0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.writedata = '0;

        idle(3);
        expect_now("reset_readdata", bus.readdata, 32'h0);
        expect_now("reset_rdreq", 32'(fifo_rdreq), 32'h0);
        reset_n = 1'b1;
        idle(1);
        rd(2'd1, "status_reset", 32'h0000_0002);

        push(9'h0A5);
        push(9'h1FF);
        idle(3);
        rd(2'd0, "data_0a5", 32'h8000_00A5);
        idle(1);
        rd(2'd0, "data_1ff", 32'h8000_01FF);
        idle(1);
        rd(2'd1, "status_cnt2", 32'h0002_0002);

        // Back-to-back DATA reads: second finds no prefetched word.
        push(9'h0AA);
        idle(3);
        @(negedge clk);
        bus.address = 2'd0;
        bus.read    = 1'b1;
        exp_q.push_back('{"data_0aa", 32'h0, 32'h8000_00AA});
        exp_q.push_back('{"data_b2b_underflow", 32'h0, 32'h0000_0000});
        @(negedge clk);
        @(negedge clk);
        bus.read = 1'b0;
        idle(1);
        rd(2'd1, "status_uflow", 32'h0003_0006);
        rd(2'd0, "data_empty", 32'h0000_0000);
        wr(2'd2, 32'h2);
        rd(2'd1, "status_clear", 32'h0000_0002);

        // Flush while the FSM waits for 0x033: that word is dropped.
        rq0 = rdreq_cnt;
        @(negedge clk);
        push_en   = 1'b1;
        push_word = 9'h033;
        @(negedge clk);
        push_word = 9'h044;
        @(negedge clk);
        push_en       = 1'b0;
        bus.address   = 2'd2;
        bus.writedata = 32'h1;
        bus.write     = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
        idle(3);
        rd(2'd0, "data_after_flush", 32'h8000_0044);
        idle(1);
        expect_now("rdreq_per_word", 32'(rdreq_cnt - rq0), 32'd2);
        rd(2'd1, "status_after_flush", 32'h0001_0002);

        wr(2'd2, 32'h2);
        for (int i = 0; i < 17; i++) begin
            w = 9'(i * 5 + 1);
            push(w);
            idle(3);
            rd(2'd0, "wrap_data", 32'h8000_0000 | 32'(w));
        end
        rd(2'd1, "status_wrap", 32'h0001_0002);

`ifdef SPW_RX_PORT_IRQ_EN
        wr(2'd3, 32'h2);
        rd(2'd3, "irq_mask", 32'h0000_0002);
        push(9'h055);
        idle(3);
        expect_now("irq_plain_word", 32'(irq), 32'h0);
        rd(2'd0, "data_055", 32'h8000_0055);
        push(9'h100);
        idle(3);
        expect_now("irq_eop_word", 32'(irq), 32'h1);
        rd(2'd0, "data_100", 32'h8000_0100);
        expect_now("irq_after_read", 32'(irq), 32'h0);
`else
        wr(2'd3, 32'h3);
        rd(2'd3, "irq_mask_absent", 32'h0000_0000);
`endif

        idle(4);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
